// File: rtl/opll_sched_pkg.sv
// Shared types for the OPLL write scheduler: source ids, queued entry format,
// scheduler states and the round-robin successor helper.
package opll_sched_pkg;

  localparam int unsigned NUM_SRC = 3;

  typedef enum logic [1:0] {
    SRC_MEM_A = 2'd0,
    SRC_MEM_B = 2'd1,
    SRC_IO    = 2'd2
  } src_e;

  typedef struct packed {
    logic       a0;
    logic [7:0] data;
  } opll_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  function automatic src_e next_src(input src_e s);
    return (s == SRC_IO) ? SRC_MEM_A : src_e'(s + 2'd1);
  endfunction

endpackage

// File: rtl/opll_wr_fifo.sv
// Small synchronous FIFO of OPLL write entries; head is show-ahead and a push
// into a full FIFO is accepted when the same cycle pops.
module opll_wr_fifo
  import opll_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  opll_entry_t din,
  input  logic        pop,
  output opll_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  opll_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/opll_write_scheduler.sv
// Merges OPLL register writes from two FM-PAC slots and the I/O ports into one
// OPLL core, spacing writes by ce_opll ticks and keeping address/data pairs together.
module opll_write_scheduler
  import opll_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WAIT  = 12,
  parameter int unsigned DATA_WAIT  = 84,
  parameter int unsigned LOCK_HOLD  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_opll,
  input  logic [2:0]  src_wr,
  input  logic [2:0]  src_a0,
  input  logic [23:0] src_data,
  input  logic [1:0]  io_enable,
  output logic        opll_we,
  output logic        opll_a0,
  output logic [7:0]  opll_dout,
  output logic        busy,
  output logic [2:0]  overflow
);

  localparam int unsigned LOCK_W = $clog2(LOCK_HOLD + 1);
  localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(LOCK_HOLD);
  localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);
  localparam logic [6:0] ADDR_TICKS = 7'(ADDR_WAIT);
  localparam logic [6:0] DATA_TICKS = 7'(DATA_WAIT);

  state_e              state, state_nx;
  src_e                grant, grant_nx;
  src_e                rr_start;
  src_e                cand;
  logic                found;
  logic                lock;
  src_e                lock_src;
  logic [LOCK_W-1:0]   lock_cnt;
  logic                lock_tick;
  logic                lock_release;
  logic [6:0]          wait_cnt;

  opll_entry_t         din  [NUM_SRC];
  opll_entry_t         head [NUM_SRC];
  logic [NUM_SRC-1:0]  push, pop, drop, full, empty;

  // The I/O source is only live while some FM-PAC instance enables its ports.
  assign push = src_wr & {|io_enable, 2'b11};
  assign pop  = (state == ISSUE) ? (3'b001 << grant) : '0;
  assign drop = push & full & ~pop;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign din[i] = {src_a0[i], src_data[8*i +: 8]};

    opll_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push[i]),
      .din   (din[i]),
      .pop   (pop[i]),
      .head  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    lock_tick    = 1'b0;
    lock_release = 1'b0;
    found        = 1'b0;
    cand         = rr_start;
    case (state)
      IDLE: begin
        if (lock && !empty[lock_src]) begin
          grant_nx = lock_src;
          state_nx = ISSUE;
        end else if (lock && (lock_cnt < LOCK_LIM)) begin
          lock_tick = 1'b1;
        end else begin
          lock_release = 1'b1;
          for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found && !empty[cand]) begin
              found    = 1'b1;
              grant_nx = cand;
            end
            cand = next_src(cand);
          end
          if (found) state_nx = ISSUE;
        end
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (ce_opll && (wait_cnt == 7'd1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= SRC_MEM_A;
      rr_start  <= SRC_MEM_A;
      lock      <= 1'b0;
      lock_src  <= SRC_MEM_A;
      lock_cnt  <= '0;
      wait_cnt  <= '0;
      opll_a0   <= 1'b0;
      opll_dout <= '0;
      overflow  <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      overflow <= overflow | drop;
      // Output registers load on entry to ISSUE so they are valid alongside opll_we.
      if ((state == IDLE) && (state_nx == ISSUE)) begin
        opll_a0   <= head[grant_nx].a0;
        opll_dout <= head[grant_nx].data;
      end
      case (state)
        IDLE: begin
          if (lock_tick)         lock_cnt <= lock_cnt + LOCK_ONE;
          else if (lock_release) lock     <= 1'b0;
        end
        ISSUE: begin
          wait_cnt <= head[grant].a0 ? DATA_TICKS : ADDR_TICKS;
          rr_start <= next_src(grant);
          if (!head[grant].a0) begin
            lock     <= 1'b1;
            lock_src <= grant;
            lock_cnt <= '0;
          end else begin
            lock     <= 1'b0;
          end
        end
        WAIT: begin
          if (ce_opll && (wait_cnt != '0)) wait_cnt <= wait_cnt - 7'd1;
        end
        default: ;
      endcase
    end
  end

  assign opll_we = (state == ISSUE);
  assign busy    = (state != IDLE);

endmodule
